// File: rtl/lbr_dump_controller_pkg.sv
// lbr_dump_controller_pkg: LBR request codes, status-word layout and dump FSM states.
package lbr_dump_controller_pkg;
  localparam logic [1:0] LBR_REQ_NONE  = 2'b00;
  localparam logic [1:0] LBR_REQ_READ  = 2'b10;
  localparam logic [1:0] LBR_REQ_CLEAR = 2'b11;
  localparam int TOS_LSB = 0;
  typedef enum logic [3:0] {
    S_IDLE, S_RD_STAT, S_CAP_STAT, S_HDR, S_RD_WORD, S_CAP_WORD, S_SEND, S_CLEAR, S_DONE
  } state_t;
  function automatic int stat_addr(input int num_entries);
    return 2 * num_entries;
  endfunction
  function automatic int full_bit(input int data_width);
    return data_width - 1;
  endfunction
endpackage

// File: rtl/lbr_dump_controller.sv
// lbr_dump_controller: freezes the LBR, streams header plus oldest-to-newest records, optionally clears.
module lbr_dump_controller
  import lbr_dump_controller_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDRESS_BITS = 12,
  parameter int NUM_ENTRIES  = 8
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic                    i_clear_en,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_lbr_freeze,
  output logic [1:0]              o_lbr_req,
  output logic [ADDRESS_BITS-1:0] o_lbr_addr,
  input  logic [DATA_WIDTH-1:0]   i_lbr_rdata,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [DATA_WIDTH-1:0]   o_out_data,
  output logic                    o_out_last
);
  localparam int INDEX_BITS = $clog2(NUM_ENTRIES);
  localparam logic [ADDRESS_BITS-1:0] STAT_ADDR = ADDRESS_BITS'(stat_addr(NUM_ENTRIES));
  localparam logic [INDEX_BITS:0] REM_ONE = (INDEX_BITS+1)'(1);
  state_t r_state, w_next;
  logic r_clr, r_half, w_full, w_last;
  logic [INDEX_BITS-1:0] r_idx, w_tos;
  logic [INDEX_BITS:0] r_rem, w_count;
  logic [DATA_WIDTH-1:0] r_data;
  assign w_tos = i_lbr_rdata[TOS_LSB +: INDEX_BITS];
  assign w_full = i_lbr_rdata[full_bit(DATA_WIDTH)];
  assign w_count = w_full ? (INDEX_BITS+1)'(NUM_ENTRIES) : {1'b0, w_tos};
  // r_rem holds the entries still to send, including the one in flight
  assign w_last = (r_state == S_HDR) ? (r_rem == '0) : (r_state == S_SEND && r_half && r_rem == REM_ONE);
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     w_next = i_start ? S_RD_STAT : S_IDLE;
      S_RD_STAT:  w_next = S_CAP_STAT;
      S_CAP_STAT: w_next = S_HDR;
      S_HDR, S_SEND: w_next = !i_out_ready ? r_state : !w_last ? S_RD_WORD : r_clr ? S_CLEAR : S_DONE;
      S_RD_WORD:  w_next = S_CAP_WORD;
      S_CAP_WORD: w_next = S_SEND;
      S_CLEAR:    w_next = S_DONE;
      default:    w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_clr   <= 1'b0;
      r_half  <= 1'b0;
      r_idx   <= '0;
      r_rem   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_start) r_clr <= i_clear_en;
      if (r_state == S_CAP_STAT) begin
        r_rem  <= w_count;
        r_idx  <= w_full ? w_tos : '0;
        r_half <= 1'b0;
        r_data <= DATA_WIDTH'(w_count);
      end
      if (r_state == S_CAP_WORD) r_data <= i_lbr_rdata;
      if (r_state == S_SEND && i_out_ready) begin
        r_half <= ~r_half;
        if (r_half) begin
          r_idx <= r_idx + 1'b1;
          r_rem <= r_rem - 1'b1;
        end
      end
    end
  end
  assign o_busy       = r_state != S_IDLE;
  assign o_lbr_freeze = o_busy;
  assign o_done       = r_state == S_DONE;
  assign o_out_valid  = r_state == S_HDR || r_state == S_SEND;
  assign o_out_last   = w_last;
  assign o_out_data   = r_data;
  assign o_lbr_req    = (r_state == S_RD_STAT || r_state == S_RD_WORD) ? LBR_REQ_READ :
                        (r_state == S_CLEAR) ? LBR_REQ_CLEAR : LBR_REQ_NONE;
  assign o_lbr_addr   = (r_state == S_RD_STAT) ? STAT_ADDR :
                        (r_state == S_RD_WORD) ? ADDRESS_BITS'({r_idx, r_half}) : '0;
endmodule

// File: tb/tb_lbr_dump_controller.sv
// tb_lbr_dump_controller: directed dumps against a small LBR memory model with stream monitor.
module tb_lbr_dump_controller;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, clear_en = 1'b0, ready = 1'b1;
  logic busy, done, freeze, valid, last;
  logic [1:0] req;
  logic [11:0] addr;
  logic [15:0] rdata = '0, odata;
  logic [15:0] mem [0:16];
  logic [16:0] q[$];
  int checks = 0, errors = 0;
  int clr_cnt = 0, rd_cnt = 0, done_cnt = 0, stall_err = 0, out_err = 0, frz_err = 0, clr_at_done = 0;
  logic p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0;
  logic [15:0] p_data = '0;
  logic [1:0] p_req = '0;

  lbr_dump_controller dut (
    .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_clear_en(clear_en),
    .o_busy(busy), .o_done(done), .o_lbr_freeze(freeze), .o_lbr_req(req),
    .o_lbr_addr(addr), .i_lbr_rdata(rdata), .o_out_valid(valid), .i_out_ready(ready),
    .o_out_data(odata), .o_out_last(last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (req == 2'b10) rdata <= (addr <= 12'd16) ? mem[addr[4:0]] : 16'hDEAD;

  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      p_valid = 1'b0;
      p_req = 2'b00;
    end else begin
      if (valid && ready) q.push_back({last, odata});
      if (p_valid && !p_ready && (!valid || odata !== p_data || last !== p_last)) stall_err++;
      if (req == 2'b10 && p_req == 2'b10) out_err++;
      if (req == 2'b10) rd_cnt++;
      if (req == 2'b11) clr_cnt++;
      if (freeze !== busy) frz_err++;
      if (done) begin
        done_cnt++;
        clr_at_done = clr_cnt;
      end
      p_valid = valid; p_ready = ready; p_data = odata; p_last = last; p_req = req;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_status(input logic full, input int tos);
    for (int k = 0; k < 8; k++) begin
      mem[2*k]   = 16'h1000 + 16'(k);
      mem[2*k+1] = 16'h2000 + 16'(k);
    end
    mem[16] = {full, 12'h000, 3'(tos)};
  endtask

  task automatic clear_stats();
    q.delete();
    clr_cnt = 0; rd_cnt = 0; done_cnt = 0; stall_err = 0; out_err = 0; frz_err = 0; clr_at_done = 0;
  endtask

  task automatic pulse_start(input logic ce);
    @(negedge clk);
    clear_en = ce;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input logic bp);
    int n = 0;
    do begin
      @(negedge clk);
      ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      n++;
    end while (!done && n < 600);
    chk("done_seen", {31'd0, done}, 32'd1);
    @(negedge clk);
    ready = 1'b1;
  endtask

  task automatic check_stream(input string tag, input int cnt, input int first);
    int k;
    chk({tag, "_len"}, q.size(), 1 + 2*cnt);
    if (q.size() == 1 + 2*cnt) begin
      chk({tag, "_hdr"}, {15'd0, q[0]}, {15'd0, (cnt == 0), 16'(cnt)});
      for (int i = 0; i < cnt; i++) begin
        k = (first + i) % 8;
        chk({tag, "_src"}, {15'd0, q[1+2*i]}, {15'd0, 1'b0, 16'h1000 + 16'(k)});
        chk({tag, "_tgt"}, {15'd0, q[2+2*i]}, {15'd0, (i == cnt-1), 16'h2000 + 16'(k)});
      end
    end
  endtask

  initial begin
    int n;
    set_status(1'b1, 3);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_freeze", {31'd0, freeze}, 0);
    chk("rst_valid", {31'd0, valid}, 0);
    chk("rst_last", {31'd0, last}, 0);
    chk("rst_req", {30'd0, req}, 0);
    chk("rst_addr", {20'd0, addr}, 0);
    chk("rst_data", {16'd0, odata}, 0);
    rst_n = 1'b1;

    // full buffer, TOS=3, no clear
    clear_stats();
    pulse_start(1'b0);
    chk("t1_busy", {31'd0, busy}, 1);
    wait_done(1'b0);
    check_stream("t1", 8, 3);
    chk("t1_clr", clr_cnt, 0);
    chk("t1_done", done_cnt, 1);
    chk("t1_reads", rd_cnt, 17);
    chk("t1_busy_end", {31'd0, busy}, 0);

    // partial buffer, TOS=5, clear afterwards
    set_status(1'b0, 5);
    clear_stats();
    pulse_start(1'b1);
    wait_done(1'b0);
    check_stream("t2", 5, 0);
    chk("t2_clr", clr_cnt, 1);
    chk("t2_clr_before_done", clr_at_done, 1);

    // empty buffer
    set_status(1'b0, 0);
    clear_stats();
    pulse_start(1'b0);
    wait_done(1'b0);
    check_stream("t3", 0, 0);
    chk("t3_reads", rd_cnt, 1);
    chk("t3_clr", clr_cnt, 0);

    // backpressure on a full dump
    set_status(1'b1, 3);
    clear_stats();
    pulse_start(1'b0);
    wait_done(1'b1);
    check_stream("t4", 8, 3);
    chk("t4_stall", stall_err, 0);
    chk("t4_outstanding", out_err, 0);
    chk("t4_freeze", frz_err, 0);

    // extra starts mid-dump and in the DONE cycle
    set_status(1'b1, 6);
    clear_stats();
    pulse_start(1'b0);
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!done && n < 600);
    chk("t5_done_seen", {31'd0, done}, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("t5_idle", {31'd0, busy}, 0);
    chk("t5_done_cnt", done_cnt, 1);
    check_stream("t5", 8, 6);

    // reset during SEND of entry 2 with clear pending
    set_status(1'b0, 5);
    clear_stats();
    pulse_start(1'b1);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(q.size() == 5 && valid) && n < 600);
    chk("t6_reached", q.size(), 5);
    ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_valid", {31'd0, valid}, 0);
    chk("t6_last", {31'd0, last}, 0);
    chk("t6_req", {30'd0, req}, 0);
    chk("t6_addr", {20'd0, addr}, 0);
    chk("t6_data", {16'd0, odata}, 0);
    chk("t6_freeze", {31'd0, freeze}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_no_clear", clr_cnt, 0);
    set_status(1'b1, 3);
    clear_stats();
    pulse_start(1'b0);
    wait_done(1'b0);
    check_stream("t6", 8, 3);
    chk("t6_clr_after", clr_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lbr_dump_controller.md
Name: lbr_dump_controller

Overview:
Sequences a complete readout of the Last Branch Record (LBR) buffer through its request/address read port. Freezes recording during the dump. Walks entries from oldest to newest, handling wrap-around. Streams the records out over a valid/ready port to a debug or trace sink, and can optionally clear the buffer afterwards. Sits between the LBR unit and the debug/trace interface; the only agent driving LBR requests.

Parameters:
DATA_WIDTH, 16, LBR read-data and stream word width
ADDRESS_BITS, 12, LBR address width
NUM_ENTRIES, 8, LBR record count; power of two, >=2
INDEX_BITS, log2(NUM_ENTRIES), entry index width (derived)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset (0 = reset)
start  in  1  one-cycle dump request; ignored while busy
clear_en  in  1  sampled with start; 1 = clear LBR after dump
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when dump (and clear) complete
lbr_freeze  out  1  to LBR stall; blocks new records during dump
lbr_req  out  2  00 none, 10 read, 11 clear
lbr_addr  out  ADDRESS_BITS  LBR word address
lbr_rdata  in  DATA_WIDTH  LBR read data, valid cycle after a read request
out_valid  out  1  stream word valid
out_ready  in  1  sink accepts word
out_data  out  DATA_WIDTH  stream word
out_last  out  1  final word of the dump

Behaviour:
- LBR map: entry k source at address 2k, target at 2k+1; status word at 2*NUM_ENTRIES: bits[INDEX_BITS-1:0] = TOS (next write slot), bit[DATA_WIDTH-1] = full.
- Reset (reset==0): state IDLE. busy, done, lbr_freeze, out_valid and out_last = 0. lbr_req = 00, lbr_addr = 0, out_data = 0. Reset mid-dump aborts immediately; no clear is issued.
- FSM: IDLE, RD_STAT, CAP_STAT, HDR, RD_WORD, CAP_WORD, SEND, CLEAR, DONE.
- IDLE: start=1 -> latch clear_en; go to RD_STAT; busy=1, lbr_freeze=1 from the next cycle, held until DONE exits.
- RD_STAT: lbr_req=10, lbr_addr=2*NUM_ENTRIES. -> CAP_STAT.
- CAP_STAT: capture status word.
  - count = full ? NUM_ENTRIES : TOS.
  - start index = full ? TOS : 0.
  - -> HDR.
- HDR: out_valid=1, out_data = count zero-extended. out_last=1 iff count==0. Hold until out_ready. Then -> RD_WORD, or -> CLEAR/DONE when count==0.
- RD_WORD: lbr_req=10, lbr_addr = 2*idx + half (half 0 = source, 1 = target). -> CAP_WORD.
- CAP_WORD: register lbr_rdata into out_data. -> SEND.
- SEND: out_valid=1; out_data and out_last stable until out_ready.
  - On handshake, if half=0: half=1.
  - Otherwise: half=0, idx = (idx+1) mod NUM_ENTRIES, and remaining count decrements.
  - out_last=1 on the target word of the final entry.
  - After last -> CLEAR if latched clear_en, else DONE; otherwise -> RD_WORD.
- Minimum 3 cycles per data word. One read outstanding at most. lbr_req=00 in every state other than RD_STAT, RD_WORD and CLEAR.
- CLEAR: lbr_req=11 for exactly one cycle. -> DONE.
- DONE: done=1 for one cycle; busy and lbr_freeze drop the following cycle. -> IDLE.
- Wrap: idx wraps NUM_ENTRIES-1 -> 0. Order is strictly oldest to newest.
- start while busy: ignored, no queuing. start in the same cycle as DONE is also ignored.
- out_ready high while out_valid low has no effect. out_valid never deasserts without a handshake (except reset).
- Total stream length = 1 + 2*count words.

Decomposition:
- Shared package:
  - LBR request encodings (LBR_REQ_NONE=00, LBR_REQ_READ=10, LBR_REQ_CLEAR=11).
  - Status-word field positions (TOS field, full bit).
  - Status-address formula 2*NUM_ENTRIES.
  - FSM state encoding.
- No sub-module: a single FSM with idx, half and remaining counters.

Test Plan:
- Full buffer, TOS=3, clear_en=0, out_ready=1 -> header 8; 16 words in entry order 3,4,5,6,7,0,1,2 (source before target); out_last on 17th word; done pulse; no lbr_req=11.
- Partial buffer (full=0, TOS=5), clear_en=1 -> header 5; entries 0..4 (10 words); then exactly one lbr_req=11 cycle; then done.
- Empty buffer (full=0, TOS=0) -> single header word 0 with out_last=1; no entry reads; done.
- Random out_ready backpressure (~50% duty) on full dump -> out_data and out_last stable while stalled; no word lost or duplicated; one read outstanding max; lbr_freeze high throughout busy.
- start pulsed again mid-dump and in the DONE cycle -> ignored; exactly one stream produced.
- reset=0 during SEND of entry 2 with clear_en=1 -> next cycle all outputs at reset values; no clear issued; fresh start then performs a full correct dump.
